perf_monitor: RTL



---
 rtl/perf_monitor.sv | 80 ++++++++
 1 files changed

// File: rtl/perf_monitor.sv
// perf_monitor: cycle/instruction performance monitor for RISC_VCPU with halt freeze and registered read port
// Ports: clk, rst (sync active-low); memIns_en/ins/pc tap the fetch bus; start/stop/clear control counting;
//   rd_req/rd_sel give rd_data/rd_valid one cycle later; running/halted mirror the state.
// Build option PERF_HALT_DETECT_EN enables freezing on HLT_OPCODE and halt_pc capture.
module perf_monitor #(
  parameter int         CNT_W      = 32,
  parameter logic [7:0] HLT_OPCODE = 8'h00
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             memIns_en,
  input  logic [7:0]       ins,
  input  logic [7:0]       pc,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  input  logic             rd_req,
  input  logic [1:0]       rd_sel,
  output logic [CNT_W-1:0] rd_data,
  output logic             rd_valid,
  output logic             running,
  output logic             halted
);
  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;
  state_t state, nxt;
  logic [CNT_W-1:0] cycle_cnt, instr_cnt, instr_snap, cycle_nxt, instr_nxt, rd_mux;
  logic [7:0] halt_pc;
  logic ovf, hlt, cnt_en;
`ifdef PERF_HALT_DETECT_EN
  assign hlt = memIns_en && ins == HLT_OPCODE;
`else
  logic unused_halt;
  assign hlt = 1'b0;
  assign unused_halt = ^{ins, pc, HLT_OPCODE};
`endif
  // stop outranks start in IDLE; HALTED is left only through clear
  assign nxt = clear ? IDLE :
               state == IDLE ? (start && !stop ? RUN : IDLE) :
               state == RUN ? (stop ? IDLE : hlt ? HALTED : RUN) : state;
  assign cnt_en = state == RUN && !clear && !stop;
  assign cycle_nxt = cnt_en && !(&cycle_cnt) ? cycle_cnt + CNT_W'(1) : cycle_cnt;
  assign instr_nxt = cnt_en && memIns_en && !(&instr_cnt) ? instr_cnt + CNT_W'(1) : instr_cnt;
  assign rd_mux = rd_sel == 2'd0 ? cycle_cnt :
                  rd_sel == 2'd1 ? instr_snap :
                  rd_sel == 2'd2 ? CNT_W'({ovf, halted, running}) : CNT_W'(halt_pc);
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      running    <= 1'b0;
      halted     <= 1'b0;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
      cycle_cnt  <= '0;
      instr_cnt  <= '0;
      instr_snap <= '0;
      halt_pc    <= '0;
      ovf        <= 1'b0;
    end else begin
      state    <= nxt;
      running  <= nxt == RUN;
      halted   <= nxt == HALTED;
      rd_valid <= rd_req;
      if (rd_req) rd_data <= rd_mux;
      if (clear) begin
        cycle_cnt  <= '0;
        instr_cnt  <= '0;
        instr_snap <= '0;
        halt_pc    <= '0;
        ovf        <= 1'b0;
      end else begin
        cycle_cnt <= cycle_nxt;
        instr_cnt <= instr_nxt;
        ovf       <= ovf | (&cycle_nxt) | (&instr_nxt);
        // snapshot takes the pre-increment count so the pair read is coherent
        if (rd_req && rd_sel == 2'd0) instr_snap <= instr_cnt;
        if (cnt_en && hlt) halt_pc <= pc;
      end
    end
  end
endmodule
